// File: rtl/fmuls_pkg.sv
// Shared types and constants for the FMULS writeback sequencer.
package fmuls_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_e;

  localparam int SREG_C_BIT = 0;
  localparam int SREG_Z_BIT = 1;
  localparam int R0_IDX     = 0;
  localparam int R1_IDX     = 1;

endpackage

// File: rtl/fmuls_sat.sv
// Combinational saturation and zero detect on the 16-bit FMULS result.
// Saturation of -1.0 x -1.0 is only active when FMULS_WB_SAT_EN is defined.
module fmuls_sat (
  input  logic [15:0] val_i,
  input  logic        prod_msb_i,
  output logic [15:0] val_o,
  output logic        sat_o,
  output logic        zero_o
);

`ifdef FMULS_WB_SAT_EN
  // 0x8000 with a clear product MSB can only come from -1.0 x -1.0.
  assign sat_o = (val_i == 16'h8000) && !prod_msb_i;
`else
  logic unused_prod_msb;
  assign unused_prod_msb = prod_msb_i;
  assign sat_o           = 1'b0;
`endif

  assign val_o  = sat_o ? 16'h7FFF : val_i;
  assign zero_o = (val_o == 16'h0000);

endmodule

// File: rtl/fmuls_wb_seq.sv
// FMULS writeback sequencer: captures R1:R0, writes R0 then R1, updates SREG C/Z.
// Optional saturation of the single overflow case via FMULS_WB_SAT_EN.
// Handshake: a result is accepted on a rising edge where i_valid && o_ready;
// upstream holds data until then, and i_valid while o_ready=0 is ignored.
module fmuls_wb_seq
  import fmuls_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int LO_ADDR = R0_IDX,
  parameter int HI_ADDR = R1_IDX
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [7:0]        i_r1,
  input  logic [7:0]        i_r0,
  input  logic              i_prod_msb,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_addr,
  output logic [7:0]        o_rf_data,
  output logic              o_sreg_we,
  output logic              o_flag_c,
  output logic              o_flag_z,
  output logic              o_sat,
  output logic              o_done,
  output logic [1:0]        o_dbg_state
);

  state_e              state_q;
  logic                ready_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          data_q;
  logic                sreg_we_q;
  logic [1:0]          sreg_q;
  logic                sat_q;
  logic                done_q;
  logic [7:0]          hi_q;
  logic [1:0]          cap_flags_q;
  logic                cap_sat_q;

  logic [15:0]         val_d;
  logic                sat_d;
  logic                zero_d;
  logic                accept;

  assign accept = i_valid && ready_q;

  fmuls_sat u_sat (
    .val_i      ({i_r1, i_r0}),
    .prod_msb_i (i_prod_msb),
    .val_o      (val_d),
    .sat_o      (sat_d),
    .zero_o     (zero_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sreg_we_q   <= 1'b0;
      sreg_q      <= '0;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
      hi_q        <= '0;
      cap_flags_q <= '0;
      cap_sat_q   <= 1'b0;
    end else begin
      // Every output is a pulse for one state; default them all quiet.
      ready_q   <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      sreg_we_q <= 1'b0;
      sreg_q    <= '0;
      sat_q     <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        WR_LO: begin
          state_q   <= WR_HI;
          we_q      <= 1'b1;
          addr_q    <= ADDR_W'(HI_ADDR);
          data_q    <= hi_q;
          sreg_we_q <= 1'b1;
          sreg_q    <= cap_flags_q;
          sat_q     <= cap_sat_q;
          done_q    <= 1'b1;
        end
        default: begin
          // IDLE and WR_HI both accept; WR_HI accepting gives back-to-back.
          if (accept) begin
            state_q                 <= WR_LO;
            ready_q                 <= 1'b0;
            we_q                    <= 1'b1;
            addr_q                  <= ADDR_W'(LO_ADDR);
            data_q                  <= val_d[7:0];
            hi_q                    <= val_d[15:8];
            cap_flags_q[SREG_C_BIT] <= i_prod_msb;
            cap_flags_q[SREG_Z_BIT] <= zero_d;
            cap_sat_q               <= sat_d;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_rf_we     = we_q;
  assign o_rf_addr   = addr_q;
  assign o_rf_data   = data_q;
  assign o_sreg_we   = sreg_we_q;
  assign o_flag_c    = sreg_q[SREG_C_BIT];
  assign o_flag_z    = sreg_q[SREG_Z_BIT];
  assign o_sat       = sat_q;
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule
